mul_add_64: RTL and testbench

// Iterative multiply-accumulate: product_out = multiplicand_in * multiplier_in + addend_in, 32x32 -> 64 bit.

---
 rtl/mul_add_64.sv | 140 ++++++++++++++
 tb/tb_mul_add_64.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_64.sv
// Iterative shift-add multiply-accumulate: product = A * B + addend, one product bit per clock.
// Signed operands are multiplied as magnitudes; the sign is applied before the final add.
module mul_add_64 #(
    parameter int unsigned OP_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_in,
    input  logic [OP_WIDTH-1:0]     multiplicand_in,
    input  logic [OP_WIDTH-1:0]     multiplier_in,
    input  logic [2*OP_WIDTH-1:0]   addend_in,
    input  logic                    is_signed_mul,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [2*OP_WIDTH-1:0]   product_out,
    output logic                    overflow_flag
);

    localparam int unsigned PW = 2 * OP_WIDTH;
    localparam int unsigned CW = $clog2(OP_WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    state_e               state_q, state_d;
    logic [OP_WIDTH-1:0]  mag_a_q, mag_a_d;
    logic [OP_WIDTH-1:0]  mag_b_q, mag_b_d;
    logic [PW-1:0]        addend_q, addend_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic                 signed_q, signed_d;
    logic [PW-1:0]        product_q, product_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [PW-1:0]        partial;
    logic [PW-1:0]        fix_p;
    logic [PW:0]          fix_sum;
    logic                 last_step;

    assign a_neg     = is_signed_mul & multiplicand_in[OP_WIDTH-1];
    assign b_neg     = is_signed_mul & multiplier_in[OP_WIDTH-1];
    assign partial   = PW'(mag_a_q) << count_q;
    assign last_step = (count_q == CW'(OP_WIDTH - 1));

    // Magnitude product is at most 2^(PW-2), so negation and the 65-bit add never lose bits.
    assign fix_p     = neg_q ? (PW'(0) - acc_q) : acc_q;
    assign fix_sum   = {1'b0, fix_p} + {1'b0, addend_q};

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        addend_d  = addend_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        signed_d  = signed_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    mag_a_d  = a_neg ? (OP_WIDTH'(0) - multiplicand_in) : multiplicand_in;
                    mag_b_d  = b_neg ? (OP_WIDTH'(0) - multiplier_in) : multiplier_in;
                    neg_d    = a_neg ^ b_neg;
                    addend_d = addend_in;
                    signed_d = is_signed_mul;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + partial;
                end
                mag_b_d = mag_b_q >> 1;
                count_d = count_q + CW'(1);
                if (last_step) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                product_d = fix_sum[PW-1:0];
                if (signed_q) begin
                    ovf_d = (fix_p[PW-1] == addend_q[PW-1]) && (fix_sum[PW-1] != fix_p[PW-1]);
                end else begin
                    ovf_d = fix_sum[PW];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            addend_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            addend_q  <= addend_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            signed_q  <= signed_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy_out      = (state_q != StIdle);
    assign done_out      = done_q;
    assign product_out   = product_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_mul_add_64.sv
// Directed bench for mul_add_64: expected results are queued at start and checked at done.
module tb_mul_add_64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic [31:0] multiplicand_in;
    logic [31:0] multiplier_in;
    logic [63:0] addend_in;
    logic        is_signed_mul;
    logic        busy_out;
    logic        done_out;
    logic [63:0] product_out;
    logic        overflow_flag;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [63:0] exp_prod_q[$];
    logic        exp_ovf_q[$];
    logic [63:0] last_prod;
    logic        last_ovf;

    mul_add_64 #(.OP_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_in        (start_in),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .addend_in       (addend_in),
        .is_signed_mul   (is_signed_mul),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .product_out     (product_out),
        .overflow_flag   (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference via full-width arithmetic on sign-extended operands.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] c, input logic sgn);
        logic [63:0] p;
        logic [64:0] s;
        if (sgn) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            s = {p[63], p} + {c[63], c};
            return {s[64] != s[63], s[63:0]};
        end else begin
            p = {32'd0, a} * {32'd0, b};
            s = {1'b0, p} + {1'b0, c};
            return s;
        end
    endfunction

    // Called just after a rising edge; the start is accepted at the next edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] c,
                            input logic sgn, input logic [63:0] ep, input logic eo,
                            input bit push);
        start_in        = 1'b1;
        multiplicand_in = a;
        multiplier_in   = b;
        addend_in       = c;
        is_signed_mul   = sgn;
        @(posedge clk);
        #1;
        start_in        = 1'b0;
        multiplicand_in = $urandom;
        multiplier_in   = $urandom;
        addend_in       = {$urandom, $urandom};
        is_signed_mul   = $urandom_range(0, 1);
        check("busy_after_accept", 64'(busy_out), 64'd1);
        if (push) begin
            exp_prod_q.push_back(ep);
            exp_ovf_q.push_back(eo);
        end
    endtask

    task automatic start_model(input logic [31:0] a, input logic [31:0] b, input logic [63:0] c,
                               input logic sgn);
        logic [64:0] m;
        m = model(a, b, c, sgn);
        start_op(a, b, c, sgn, m[63:0], m[64], 1'b1);
    endtask

    // Waits for done; lat is the number of edges expected from now until done is seen.
    task automatic wait_done(input string tag, input int lat);
        int k;
        logic [63:0] ep;
        logic        eo;
        k = 0;
        while (k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (done_out) break;
        end
        check({tag, "_latency"}, 64'(k), 64'(lat));
        if (done_out && exp_prod_q.size() > 0) begin
            ep = exp_prod_q.pop_front();
            eo = exp_ovf_q.pop_front();
            check({tag, "_product"}, product_out, ep);
            check({tag, "_ovf"}, 64'(overflow_flag), 64'(eo));
            check({tag, "_busy_at_done"}, 64'(busy_out), 64'd0);
            last_prod = ep;
            last_ovf  = eo;
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_done: observed no result expected done with queued result", tag);
        end
    endtask

    task automatic check_hold(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done_out), 64'd0);
        check({tag, "_hold_product"}, product_out, last_prod);
        check({tag, "_hold_ovf"}, 64'(overflow_flag), 64'(last_ovf));
    endtask

    initial begin
        int seen;
        reset           = 1'b1;
        start_in        = 1'b0;
        multiplicand_in = '0;
        multiplier_in   = '0;
        addend_in       = '0;
        is_signed_mul   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_product", product_out, 64'd0);
        check("rst_ovf", 64'(overflow_flag), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, 64'hFFFFFFFE00000001, 1'b0, 1'b1);
        wait_done("u_max", 33);
        check_hold("u_max");

        start_op(32'hFFFFFFFD, 32'd7, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFEB, 1'b0, 1'b1);
        wait_done("s_neg3x7", 33);
        check_hold("s_neg3x7");

        start_op(32'h80000000, 32'h80000000, 64'd0, 1'b1, 64'h4000000000000000, 1'b0, 1'b1);
        wait_done("s_minmin", 33);

        start_op(32'd14, 32'd7, 64'd2, 1'b0, 64'd100, 1'b0, 1'b1);
        wait_done("div_u", 33);

        start_op(32'hFFFFFFF2, 32'd7, 64'hFFFFFFFFFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFFFF9C, 1'b0, 1'b1);
        wait_done("div_s", 33);

        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000200000000, 1'b0, 64'd1, 1'b1, 1'b1);
        wait_done("u_ovf", 33);
        check_hold("u_ovf");

        start_op(32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1, 64'h8000000000000000,
                 1'b1, 1'b1);
        wait_done("s_ovf", 33);

        start_op(32'd0, 32'h12345678, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF, 1'b0,
                 1'b1);
        wait_done("zero_a", 33);

        for (int i = 0; i < 4; i++) begin
            start_model($urandom, $urandom, {$urandom, $urandom}, 1'(i));
            wait_done("rand", 33);
        end

        // Start while busy is ignored; operands of the ignored request must not leak in.
        start_op(32'd1000, 32'd3, 64'd5, 1'b0, 64'd3005, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        start_in        = 1'b1;
        multiplicand_in = 32'd9;
        multiplier_in   = 32'd9;
        addend_in       = 64'd0;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        wait_done("ignored_start", 27);

        // Start in the done cycle is accepted back to back.
        start_op(32'hFFFFFFFF, 32'd2, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1);
        wait_done("b2b_first", 33);
        start_op(32'd6, 32'd7, 64'd0, 1'b0, 64'd42, 1'b0, 1'b1);
        wait_done("b2b_second", 33);
        check_hold("b2b_second");

        // Reset mid-operation aborts with no completion.
        start_op(32'd5, 32'd5, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy_out), 64'd0);
        check("abort_product", product_out, 64'd0);
        check("abort_ovf", 64'(overflow_flag), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_out) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        start_op(32'hFFFFFFF9, 32'hFFFFFFFA, 64'd8, 1'b1, 64'd50, 1'b0, 1'b1);
        wait_done("after_reset", 33);

        check("queue_empty", 64'(exp_prod_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
